// File: rtl/fsm_fetch.sv
// -----------------------------------------------------------------------------
// fsm_fetch
//
// Program sequencer upstream of the instruction decoder. A short program is
// written into a small program memory through a valid/ready load port. On
// start the stored program is issued one instruction per cycle as registered
// opcode/operand fields. The program runs for loop_count passes (0 counts as 1)
// and stops early at a HALT opcode (all ones), which is never issued.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; returns to IDLE and empties program
//   load_valid   load_instr carries an instruction to append
//   load_ready   the presented load is accepted this cycle (IDLE, not full,
//                no start/clear/reset in the same cycle)
//   load_instr   packed {opcode, operand1, operand2}
//   start        pulse; runs the stored program (IDLE with a program, or DONE)
//   clear        abort, empty the program and return to IDLE (highest priority)
//   loop_count   number of passes, sampled with start
//   stall        freezes issue; each stalled cycle gives instr_valid=0
//   opcode       registered opcode field
//   operand1/2   registered operand fields
//   instr_valid  fields hold a newly issued instruction this cycle
//   busy         state is RUN
//   done         state is DONE
// -----------------------------------------------------------------------------
module fsm_fetch #(
    parameter int SIZE       = 4,
    parameter int PROG_DEPTH = 16,
    parameter int PC_W       = 4,
    parameter int INSTR_W    = 3 * SIZE - 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic               start,
    input  logic               clear,
    input  logic [7:0]         loop_count,
    input  logic               stall,
    output logic [SIZE-2:0]    opcode,
    output logic [SIZE-3:0]    operand1,
    output logic [SIZE-3:0]    operand2,
    output logic               instr_valid,
    output logic               busy,
    output logic               done
);

    localparam int OP_W  = SIZE - 1;
    localparam int OPD_W = SIZE - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Program memory. Contents are deliberately not reset; wr_ptr alone
    // defines which entries form the current program.
    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    state_t            state_reg,       state_next;
    logic [PC_W:0]     wr_ptr_reg,      wr_ptr_next;
    logic [PC_W-1:0]   pc_reg,          pc_next;
    logic [7:0]        iter_left_reg,   iter_left_next;
    logic [OP_W-1:0]   opcode_reg,      opcode_next;
    logic [OPD_W-1:0]  operand1_reg,    operand1_next;
    logic [OPD_W-1:0]  operand2_reg,    operand2_next;
    logic              instr_valid_reg, instr_valid_next;

    logic               full;
    logic               load_fire;
    logic [INSTR_W-1:0] fetch_instr;
    logic [OP_W-1:0]    fetch_op;
    logic               fetch_halt;
    logic               last_pc;
    logic [7:0]         start_iter;

    // wr_ptr is one bit wider than pc so that a completely full memory is
    // distinguishable from an empty one.
    assign full       = (wr_ptr_reg == (PC_W+1)'(PROG_DEPTH));
    assign load_ready = (state_reg == ST_IDLE) && !full && !start && !clear && !reset;
    assign load_fire  = load_valid && load_ready;

    // Fetch reads the memory combinationally; the output field registers act
    // as the read register, so the decision on HALT and the issued fields come
    // from the same fetched word.
    assign fetch_instr = mem[pc_reg];
    assign fetch_op    = fetch_instr[INSTR_W-1 -: OP_W];
    assign fetch_halt  = (fetch_op == {OP_W{1'b1}});
    assign last_pc     = ({1'b0, pc_reg} == (wr_ptr_reg - (PC_W+1)'(1)));
    assign start_iter  = (loop_count == 8'd0) ? 8'd1 : loop_count;

    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[wr_ptr_reg[PC_W-1:0]] <= load_instr;
        end
    end

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        pc_next          = pc_reg;
        iter_left_next   = iter_left_reg;
        opcode_next      = opcode_reg;
        operand1_next    = operand1_reg;
        operand2_next    = operand2_reg;
        instr_valid_next = 1'b0;

        if (clear) begin
            state_next     = ST_IDLE;
            wr_ptr_next    = '0;
            pc_next        = '0;
            iter_left_next = '0;
            opcode_next    = '0;
            operand1_next  = '0;
            operand2_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_fire) begin
                        wr_ptr_next = wr_ptr_reg + (PC_W+1)'(1);
                    end
                    // A start with no program loaded is ignored.
                    if (start && (wr_ptr_reg != '0)) begin
                        pc_next        = '0;
                        iter_left_next = start_iter;
                        state_next     = ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (!stall) begin
                        opcode_next   = fetch_op;
                        operand1_next = fetch_instr[INSTR_W-OP_W-1 -: OPD_W];
                        operand2_next = fetch_instr[OPD_W-1:0];
                        if (fetch_halt) begin
                            // Fields still load, but the HALT is never issued.
                            state_next = ST_DONE;
                        end else begin
                            instr_valid_next = 1'b1;
                            if (last_pc) begin
                                if (iter_left_reg > 8'd1) begin
                                    // Wrap with no bubble between passes.
                                    pc_next        = '0;
                                    iter_left_next = iter_left_reg - 8'd1;
                                end else begin
                                    // Final issue and RUN->DONE share this edge.
                                    iter_left_next = '0;
                                    state_next     = ST_DONE;
                                end
                            end else begin
                                pc_next = pc_reg + PC_W'(1);
                            end
                        end
                    end
                end

                ST_DONE: begin
                    // Re-run the stored program; in DONE a program always exists.
                    if (start) begin
                        pc_next        = '0;
                        iter_left_next = start_iter;
                        state_next     = ST_RUN;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            pc_reg          <= '0;
            iter_left_reg   <= '0;
            opcode_reg      <= '0;
            operand1_reg    <= '0;
            operand2_reg    <= '0;
            instr_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            pc_reg          <= pc_next;
            iter_left_reg   <= iter_left_next;
            opcode_reg      <= opcode_next;
            operand1_reg    <= operand1_next;
            operand2_reg    <= operand2_next;
            instr_valid_reg <= instr_valid_next;
        end
    end

    assign opcode      = opcode_reg;
    assign operand1    = operand1_reg;
    assign operand2    = operand2_reg;
    assign instr_valid = instr_valid_reg;
    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_DONE);

endmodule
